// File: rtl/uart_rx_pkg.sv
// ============================================================================
// Module : uart_rx_pkg
// Brief  : FSM state encoding and width helper shared by the UART receiver.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package uart_rx_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Counter width that stays legal (>= 1 bit) for degenerate sizes.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync_2ff.sv
// ============================================================================
// Module : uart_rx_sync_2ff
// Brief  : Two-flop synchroniser with a parameterised reset value.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_rx_sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= RESET_VAL;
      q      <= RESET_VAL;
    end else begin
      r_meta <= d;
      q      <= r_meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module : uart_rx
// Brief  : 8N1 UART receiver with mid-bit sampling; writes good bytes to the
//          RX FIFO and pulses framing-error / overrun flags.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  input  logic                 fifo_full,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 wr_en,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam int IDX_W = cnt_width(DATA_BITS);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(DATA_BITS - 1);

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt, w_shift_in;
  logic [DATA_BITS-1:0] w_data_nxt;
  logic                 w_wr_nxt, w_fe_nxt, w_ov_nxt;
  logic                 w_rxd_s, r_rxd_d, w_fall;

  uart_rx_sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rxd),
    .q     (w_rxd_s)
  );

  assign w_fall = r_rxd_d & ~w_rxd_s;
  assign busy   = (r_state != S_IDLE);

  // LSB-first line: each new bit enters at the MSB and the word shifts right.
  if (DATA_BITS > 1) begin : g_shift_wide
    assign w_shift_in = {w_rxd_s, r_shift[DATA_BITS-1:1]};
  end else begin : g_shift_single
    assign w_shift_in = w_rxd_s;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = data_out;
    w_wr_nxt    = 1'b0;
    w_fe_nxt    = 1'b0;
    w_ov_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_fall) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (r_cnt == C_CNT_MID) begin
          w_cnt_nxt = '0;
          if (!w_rxd_s) begin
            w_state_nxt = S_DATA;
            w_idx_nxt   = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (r_cnt == C_CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = w_shift_in;
          if (r_idx == C_IDX_LAST) begin
            w_state_nxt = S_STOP;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      S_STOP: begin
        // Leaving at mid-stop lets an immediately following start bit be caught.
        if (r_cnt == C_CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
          if (w_rxd_s) begin
            if (!fifo_full) begin
              w_data_nxt = r_shift;
              w_wr_nxt   = 1'b1;
            end else begin
              w_ov_nxt = 1'b1;
            end
          end else begin
            w_fe_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_rxd_d   <= 1'b1;
      data_out  <= '0;
      wr_en     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_rxd_d   <= w_rxd_s;
      data_out  <= w_data_nxt;
      wr_en     <= w_wr_nxt;
      frame_err <= w_fe_nxt;
      overrun   <= w_ov_nxt;
    end
  end

endmodule

`default_nettype wire
